// File: rtl/burst_lane_ram_pkg.sv
// burst_lane_ram shared types and default geometry.
// Used by burst_lane_ram and blr_lane_decode.
package burst_lane_ram_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 32;
  localparam int DEF_N_LANES    = 7;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    CLEAR
  } blr_state_e;

endpackage

// File: rtl/blr_lane_decode.sv
// Per-lane write address and enable generation from the write pointer.
// BURST_LANE_RAM_WRAP_EN lets lanes wrap past DEPTH-1.
module blr_lane_decode
  import burst_lane_ram_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int N_LANES = DEF_N_LANES,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic [AW-1:0]         wptr,
  input  logic                  accept,
  output logic [N_LANES*AW-1:0] lane_addr,
  output logic [N_LANES-1:0]    lane_en
);

`ifdef BURST_LANE_RAM_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic [AW:0] sum;
    assign sum = {1'b0, wptr} + (AW+1)'(k);
    assign lane_addr[k*AW +: AW] = sum[AW-1:0];
    // carry out means the lane would pass index DEPTH-1
    assign lane_en[k] = accept && (WRAP || !sum[AW]);
  end

endmodule

// File: rtl/burst_lane_ram.sv
// Multi-lane burst write RAM with 1-cycle read and sequential clear.
// BURST_LANE_RAM_WRAP_EN: writes never block, wptr wraps over old data.
module burst_lane_ram
  import burst_lane_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int N_LANES    = DEF_N_LANES,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [N_LANES*DATA_WIDTH-1:0] wr_data,
  input  logic                          rd_en,
  input  logic [AW-1:0]                 rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  input  logic                          clr,
  output logic [CW-1:0]                 level,
  output logic                          full,
  output logic                          busy
);

  localparam logic [AW-1:0] LANES_A = AW'(N_LANES);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH-1);
  localparam logic [CW-1:0] LANES_C = CW'(N_LANES);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FULL_AT = CW'(DEPTH-N_LANES);

  blr_state_e                state;
  logic [AW-1:0]             wptr;
  logic [AW-1:0]             clr_cnt;
  logic                      alive_q;
  logic                      accept;
  logic [CW:0]               lvl_sum;
  logic [CW-1:0]             lvl_nxt;
  logic [N_LANES*AW-1:0]     lane_addr;
  logic [N_LANES-1:0]        lane_en;
  logic [DATA_WIDTH-1:0]     mem [DEPTH];

  // clr in the same cycle wins over a write beat
`ifdef BURST_LANE_RAM_WRAP_EN
  assign wr_ready = alive_q && (state != CLEAR) && !clr;
`else
  assign wr_ready = alive_q && (state != CLEAR) && !clr && !full;
`endif

  assign accept  = wr_valid && wr_ready;
  assign lvl_sum = {1'b0, level} + {1'b0, LANES_C};
  assign lvl_nxt = (lvl_sum > {1'b0, DEPTH_C}) ? DEPTH_C
                                               : lvl_sum[CW-1:0];

  blr_lane_decode #(
    .DEPTH   (DEPTH),
    .N_LANES (N_LANES),
    .AW      (AW)
  ) u_decode (
    .wptr      (wptr),
    .accept    (accept),
    .lane_addr (lane_addr),
    .lane_en   (lane_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wptr    <= '0;
      clr_cnt <= '0;
      level   <= '0;
      full    <= 1'b0;
      busy    <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (clr) begin
        state   <= CLEAR;
        busy    <= 1'b1;
        clr_cnt <= '0;
        wptr    <= '0;
        level   <= '0;
        full    <= 1'b0;
      end else begin
        unique case (state)
          CLEAR: begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          IDLE, ACTIVE: begin
            if (accept) begin
              state <= ACTIVE;
              wptr  <= wptr + LANES_A;
              level <= lvl_nxt;
              full  <= (lvl_nxt > FULL_AT);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_cnt] <= '0;
    for (int k = 0; k < N_LANES; k++) begin
      if (lane_en[k])
        mem[lane_addr[k*AW +: AW]] <=
          wr_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en && (state != CLEAR);
      if (rd_en && (state != CLEAR))
        rd_data <= mem[rd_addr];
    end
  end

endmodule
